uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/conway_pkg.sv | 27 ++
 rtl/uart_cmd_parser.sv | 176 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conway_pkg.sv
// conway_pkg
// Shared definitions for the Conway board command path: opcode encodings
// carried from the UART command parser to the board controller, plus the
// ASCII byte values that make up the serial command language.
//   Opcodes : NOP, INIT, STEP, RUN_TOGGLE, SET, CLEAR, ZERO (3-bit)
//   ASCII   : ' ', '0', '1', 'C', 'S', 'Z', ESC
package conway_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_INIT       = 3'd1,
    OP_STEP       = 3'd2,
    OP_RUN_TOGGLE = 3'd3,
    OP_SET        = 3'd4,
    OP_CLEAR      = 3'd5,
    OP_ZERO       = 3'd6
  } cmd_op_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_1     = 8'h31;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;

endpackage

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Turns a stream of bytes from a UART receiver into board commands.
// Single-byte commands ('0','1',' ','Z') emit immediately; 'S'/'C' take
// two ASCII digit operands (column, then row). ESC cancels a pending
// command silently; bad digits, framing errors and inter-byte timeouts
// cancel it with a one-cycle parse_err pulse.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_error/rx_ready   byte input with handshake
//   cmd_valid/cmd_ready  command output handshake
//   cmd_op/cmd_x/cmd_y   decoded command (x/y zero unless SET/CLEAR)
//   parse_err            one-cycle pulse on an aborted command
module uart_cmd_parser
  import conway_pkg::*;
#(
  parameter int unsigned LOG_W          = 3,
  parameter int unsigned LOG_H          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2400000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_error,
  output logic             rx_ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_op,
  output logic [LOG_W-1:0] cmd_x,
  output logic [LOG_H-1:0] cmd_y,
  output logic             parse_err
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned X_SPAN = 1 << LOG_W;
  localparam int unsigned Y_SPAN = 1 << LOG_H;

  typedef enum logic [1:0] {
    IDLE,
    GET_X,
    GET_Y,
    EMIT
  } state_e;

  state_e           state;
  cmd_op_e          pend_op;
  logic [LOG_W-1:0] x_lat;
  logic [CNT_W-1:0] gap_cnt;

  logic             accept;
  logic             timeout;
  logic [7:0]       digit;
  logic             is_num;
  logic             x_ok;
  logic             y_ok;
  logic [LOG_W-1:0] x_val;
  logic [LOG_H-1:0] y_val;
  logic             idle_emit;
  logic             idle_arm;
  cmd_op_e          idle_op;

  assign accept  = rx_valid && rx_ready;
  assign timeout = (gap_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Digit range check: byte must lie in '0' .. '0' + 2^LOG - 1.
  assign digit  = rx_data - ASCII_0;
  assign is_num = (rx_data >= ASCII_0);
  assign x_ok   = is_num && ({24'b0, digit} < X_SPAN);
  assign y_ok   = is_num && ({24'b0, digit} < Y_SPAN);
  assign x_val  = LOG_W'(digit);
  assign y_val  = LOG_H'(digit);

  // Opcode decode for a byte received while idle.
  always_comb begin
    idle_emit = 1'b0;
    idle_arm  = 1'b0;
    idle_op   = OP_NOP;
    case (rx_data)
      ASCII_0:     begin idle_emit = 1'b1; idle_op = OP_INIT;       end
      ASCII_1:     begin idle_emit = 1'b1; idle_op = OP_STEP;       end
      ASCII_SPACE: begin idle_emit = 1'b1; idle_op = OP_RUN_TOGGLE; end
      ASCII_Z:     begin idle_emit = 1'b1; idle_op = OP_ZERO;       end
      ASCII_S:     begin idle_arm  = 1'b1; idle_op = OP_SET;        end
      ASCII_C:     begin idle_arm  = 1'b1; idle_op = OP_CLEAR;      end
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend_op   <= OP_NOP;
      x_lat     <= '0;
      gap_cnt   <= '0;
      rx_ready  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= OP_NOP;
      cmd_x     <= '0;
      cmd_y     <= '0;
      parse_err <= 1'b0;
    end else begin
      parse_err <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          gap_cnt  <= '0;
          if (accept) begin
            if (rx_error) begin
              parse_err <= 1'b1;
            end else if (idle_emit) begin
              cmd_valid <= 1'b1;
              cmd_op    <= idle_op;
              cmd_x     <= '0;
              cmd_y     <= '0;
              rx_ready  <= 1'b0;
              state     <= EMIT;
            end else if (idle_arm) begin
              pend_op <= idle_op;
              state   <= GET_X;
            end
          end
        end

        GET_X, GET_Y: begin
          // An accepted byte takes priority over a timeout on the same cycle.
          if (accept) begin
            gap_cnt <= '0;
            if (rx_error) begin
              parse_err <= 1'b1;
              state     <= IDLE;
            end else if (rx_data == ASCII_ESC) begin
              state <= IDLE;
            end else if (state == GET_X && x_ok) begin
              x_lat <= x_val;
              state <= GET_Y;
            end else if (state == GET_Y && y_ok) begin
              cmd_valid <= 1'b1;
              cmd_op    <= pend_op;
              cmd_x     <= x_lat;
              cmd_y     <= y_val;
              rx_ready  <= 1'b0;
              state     <= EMIT;
            end else begin
              parse_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (timeout) begin
            gap_cnt   <= '0;
            parse_err <= 1'b1;
            state     <= IDLE;
          end else if (gap_cnt != '1) begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end

        EMIT: begin
          rx_ready <= 1'b0;
          gap_cnt  <= '0;
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NOP;
            cmd_x     <= '0;
            cmd_y     <= '0;
            rx_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Scoreboard bench for uart_cmd_parser: directed scenarios followed by
// randomized byte streams. A reference model turns accepted bytes (and
// inter-byte gaps) into expected commands/errors pushed on a queue; an
// independent monitor pops and compares whenever the DUT emits.
module tb_uart_cmd_parser;
  import conway_pkg::*;

  localparam int unsigned LW = 3;
  localparam int unsigned LH = 3;
  localparam int unsigned TO = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_error = 1'b0;
  logic          rx_ready;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [2:0]    cmd_op;
  logic [LW-1:0] cmd_x;
  logic [LH-1:0] cmd_y;
  logic          parse_err;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .LOG_W(LW),
    .LOG_H(LH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_error(rx_error),
    .rx_ready(rx_ready),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .parse_err(parse_err)
  );

  typedef struct {
    bit          is_err;
    logic [2:0]  op;
    logic [2:0]  x;
    logic [2:0]  y;
    int unsigned t;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  bit          rnd_ready = 1'b0;

  function automatic exp_t mk(input bit is_err, input logic [2:0] op,
                              input int x, input int y, input int unsigned t);
    exp_t e;
    e.is_err = is_err;
    e.op     = op;
    e.x      = 3'(x);
    e.y      = 3'(y);
    e.t      = t;
    return e;
  endfunction

  // Reference model: works on accepted bytes and the gap (in cycles) since
  // the last byte of a pending two-operand command.
  initial begin
    int          mode = 0;   // 0: no command pending, 1: want column, 2: want row
    int          px = 0;
    int          v;
    logic [2:0]  pop_ = 3'd0;
    int unsigned t_last = 0;
    bit          acc;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mode = 0;
        continue;
      end
      acc = rx_valid && rx_ready;
      if (acc) begin
        v = int'(rx_data) - 48;
        if (mode == 0) begin
          if (rx_error) expq.push_back(mk(1'b1, 3'd0, 0, 0, cyc));
          else if (rx_data == 8'h30) expq.push_back(mk(1'b0, 3'd1, 0, 0, cyc));
          else if (rx_data == 8'h31) expq.push_back(mk(1'b0, 3'd2, 0, 0, cyc));
          else if (rx_data == 8'h20) expq.push_back(mk(1'b0, 3'd3, 0, 0, cyc));
          else if (rx_data == 8'h5A) expq.push_back(mk(1'b0, 3'd6, 0, 0, cyc));
          else if (rx_data == 8'h53 || rx_data == 8'h43) begin
            pop_   = (rx_data == 8'h53) ? 3'd4 : 3'd5;
            mode   = 1;
            t_last = cyc;
          end
        end else begin
          if (rx_error) begin
            expq.push_back(mk(1'b1, 3'd0, 0, 0, cyc));
            mode = 0;
          end else if (rx_data == 8'h1B) begin
            mode = 0;
          end else if (mode == 1 && v >= 0 && v < (1 << LW)) begin
            px     = v;
            mode   = 2;
            t_last = cyc;
          end else if (mode == 2 && v >= 0 && v < (1 << LH)) begin
            expq.push_back(mk(1'b0, pop_, px, v, cyc));
            mode = 0;
          end else begin
            expq.push_back(mk(1'b1, 3'd0, 0, 0, cyc));
            mode = 0;
          end
        end
      end else if (mode != 0 && (cyc - t_last) == TO + 1) begin
        expq.push_back(mk(1'b1, 3'd0, 0, 0, cyc));
        mode = 0;
      end
    end
  end

  // Monitor: compares DUT emissions against the head of the queue.
  initial begin
    bit   prev_v = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        continue;
      end
      if (parse_err) begin
        total++;
        if (expq.size() == 0 || !expq[0].is_err) begin
          bad++;
          $display("FAIL parse_err_pulse: got pulse at cycle %0d, required none (queue=%0d)",
                   cyc, expq.size());
        end else begin
          void'(expq.pop_front());
        end
      end
      if (cmd_valid) begin
        total++;
        if (rx_ready !== 1'b0) begin
          bad++;
          $display("FAIL rx_ready_in_emit: got %b, required 0", rx_ready);
        end
        total++;
        if (expq.size() == 0 || expq[0].is_err) begin
          bad++;
          $display("FAIL cmd_unexpected: got op=%0d x=%0d y=%0d at cycle %0d, required no command",
                   cmd_op, cmd_x, cmd_y, cyc);
        end else begin
          e = expq[0];
          total++;
          if (cmd_op !== e.op || cmd_x !== e.x || cmd_y !== e.y) begin
            bad++;
            $display("FAIL cmd_fields: got op=%0d x=%0d y=%0d, required op=%0d x=%0d y=%0d",
                     cmd_op, cmd_x, cmd_y, e.op, e.x, e.y);
          end
          if (!prev_v) begin
            total++;
            if (cyc != e.t) begin
              bad++;
              $display("FAIL cmd_latency: got rise at cycle %0d, required %0d", cyc, e.t);
            end
          end
          if (cmd_ready) void'(expq.pop_front());
        end
      end
      prev_v = cmd_valid;
    end
  end

  // Random consumer back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) cmd_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [7:0] b, input logic err);
    int n;
    n        = 0;
    rx_data  = b;
    rx_error = err;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        break;
      end
      @(posedge clk);
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL rx_accept_wait: got no rx_ready in 200 cycles, required acceptance");
        break;
      end
    end
    #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string name);
    total++;
    if ({rx_ready, cmd_valid, cmd_op, cmd_x, cmd_y, parse_err} !== '0) begin
      bad++;
      $display("FAIL %s: got rx_ready=%b cmd_valid=%b op=%0d x=%0d y=%0d perr=%b, required all 0",
               name, rx_ready, cmd_valid, cmd_op, cmd_x, cmd_y, parse_err);
    end
  endtask

  initial begin
    logic [7:0] pool [14];
    logic [7:0] b;
    pool = '{8'h30, 8'h31, 8'h20, 8'h5A, 8'h53, 8'h43, 8'h32, 8'h35,
             8'h37, 8'h38, 8'h39, 8'h1B, 8'h53, 8'h36};

    // Reset values and first rx_ready rise.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_values");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL rx_ready_first: got %b, required 0", rx_ready);
    end
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL rx_ready_rise: got %b, required 1", rx_ready);
    end
    @(posedge clk);
    #1;

    // STEP then RUN_TOGGLE with consumer always ready.
    cmd_ready = 1'b1;
    send(8'h31, 1'b0);
    send(8'h20, 1'b0);
    idle(3);

    // SET 3,6 held under back-pressure.
    cmd_ready = 1'b0;
    send(8'h53, 1'b0);
    send(8'h33, 1'b0);
    send(8'h36, 1'b0);
    idle(10);
    cmd_ready = 1'b1;
    idle(2);

    // Out-of-range digit aborts; next command still works.
    send(8'h43, 1'b0);
    send(8'h39, 1'b0);
    send(8'h30, 1'b0);
    idle(3);

    // Digit boundaries: '7' accepted, '8' rejected.
    send(8'h43, 1'b0);
    send(8'h37, 1'b0);
    send(8'h38, 1'b0);
    send(8'h53, 1'b0);
    send(8'h30, 1'b0);
    send(8'h37, 1'b0);
    idle(3);

    // Timeout expiry, then a byte landing on the timeout cycle.
    send(8'h53, 1'b0);
    idle(60);
    send(8'h53, 1'b0);
    idle(TO);
    send(8'h32, 1'b0);
    send(8'h35, 1'b0);
    idle(3);

    // ESC cancels silently; framing error in idle reports.
    send(8'h53, 1'b0);
    send(8'h1B, 1'b0);
    send(8'h31, 1'b1);
    idle(3);

    // Reset in the middle of a command.
    send(8'h53, 1'b0);
    send(8'h34, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("reset_midcmd");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    send(8'h5A, 1'b0);
    idle(3);

    // Randomized stream with random back-pressure and occasional long gaps.
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 13)];
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(TO - 2, TO + 2)));
      else idle(int'($urandom_range(0, 2)));
      send(b, ($urandom_range(0, 19) == 0));
    end
    rnd_ready = 1'b0;
    cmd_ready = 1'b1;
    idle(TO + 20);

    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d outstanding expectations, required 0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
